updown_counter_ext: RTL
=======================

Name: updown_counter_ext

Overview:
- Parametrised successor to the team's 8-bit load/enable counter.
- Adds up/down counting, a programmable terminal value with a wrap/saturate mode select, and a terminal-count pulse.
- Adds an overflow/underflow sticky flag and a tri-state output port with an enable.
- Sits in the TinyTapeout user design as a general event/timer counter, driven directly from pads and the user registers.

Parameters:
- WIDTH, 8, counter and data width in bits (2..32).
- RESET_VAL, 0, value of count after reset (WIDTH bits, must be <= MAX_DEFAULT).
- MAX_DEFAULT, 2**WIDTH-1, terminal value used until limit is written.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load  in  1  synchronous load of load_value into count.
- load_value  in  WIDTH  value loaded when load=1.
- set_limit  in  1  synchronous write of load_value into the limit register.
- enable  in  1  count enable.
- up  in  1  direction: 1 = increment, 0 = decrement.
- mode  in  1  0 = wrap, 1 = saturate.
- clr_flag  in  1  clears the sticky ovf flag.
- oe  in  1  output enable, active high.
- q  out  WIDTH  tri-state count output; Z when oe=0.
- tc  out  1  registered one-cycle terminal-count pulse.
- ovf  out  1  sticky wrap/saturate-hit flag.

Behaviour:
- Reset (asynchronous, rst_n=0): count=RESET_VAL, limit=MAX_DEFAULT, tc=0, ovf=0.
- q is combinational from count: q = oe ? count : all-Z. q is never registered.
- Priority per rising edge, highest first: load, then enable counting. set_limit is independent of load and enable.
- Load and set_limit in the same cycle: limit takes load_value, and count also takes load_value.
- load: count <= load_value, unclamped, even if load_value > limit. load never asserts tc or ovf.
- Up count, count < limit: count+1.
- Up count, count >= limit:
  - wrap mode: count <= 0.
  - saturate mode: count holds.
  - In both modes the edge is a terminal event.
- Down count, count > 0: count-1.
- Down count, count == 0:
  - wrap mode: count <= limit.
  - saturate mode: count holds at 0.
  - In both modes the edge is a terminal event.
- Arithmetic is WIDTH bits, unsigned. count > limit (reachable only via load):
  - counting up hits the terminal condition on the next enabled edge;
  - counting down decrements normally.
- tc is registered. It is 1 in the cycle after each enabled terminal event and 0 otherwise, so a held saturated count with enable=1 gives tc=1 on every cycle.
- ovf is set on any terminal event and cleared by clr_flag.
- If clr_flag and a terminal event occur in the same cycle, set wins: ovf=1.
- set_limit: limit <= load_value, effective on the next edge. count is not modified.
- limit=0 with enable=1:
  - up: every edge is terminal; count stays 0 (wrap) or holds (saturate).
  - down: same behaviour.
- Changing mode or up mid-count takes effect on the next edge. There is no internal state machine beyond the count and limit registers.
- Reset asserted mid-operation: all state returns to reset values immediately, without waiting for a clock edge.

Optional Feature:
- Macro: COUNTER_PRESCALE_EN.
- Defined:
  - Adds parameter PRESCALE (default 4, >= 1) and an internal prescaler of clog2(PRESCALE) bits.
  - Counting occurs only on enabled edges where the prescaler equals PRESCALE-1; the prescaler advances on every enabled edge.
  - load and reset clear the prescaler.
  - tc and ovf follow actual count steps only.
- Undefined: count steps on every enabled edge; no prescaler logic is present.

Decomposition:
- Package counter_pkg:
  - mode encoding constants MODE_WRAP=1'b0 and MODE_SAT=1'b1;
  - direction constants DIR_UP=1'b1 and DIR_DN=1'b0.
- One natural sub-module: counter_next_val.
  - Combinational; inputs count, limit, up, mode.
  - Outputs next_count and term.
  - Reused by future multi-channel counters.

Test Plan:
- Reset, WIDTH=8: rst_n=0 mid-count at 0x37 -> q=0x00 (oe=1) asynchronously, tc=0, ovf=0; with oe=0, q=Z.
- Up wrap:
  - set_limit with load_value=5, load 0, enable, up=1, mode=0, 7 edges -> q sequence 1,2,3,4,5,0,1.
  - tc=1 only in the cycle after the 5->0 step; ovf=1 and stays 1 until clr_flag.
- Down saturate: load 2, up=0, mode=1, 4 edges -> q 1,0,0,0; tc high on the last two cycles; ovf=1.
- Down wrap to limit: limit=9, count=0, up=0, mode=0, 1 edge -> q=9, tc pulse.
- Simultaneous events:
  - load=1 and enable=1 with load_value=0xAA -> q=0xAA, no tc.
  - clr_flag together with a terminal event -> ovf stays 1.
- Limit corner cases:
  - load 0xF0 with limit 0x10, count up 1 edge (wrap) -> q=0, tc=1.
  - limit=0, up=1, wrap -> q stays 0 and tc=1 every enabled cycle.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared encodings for the up/down counter family.
// Holds the mode and direction constants and a small width helper.
package counter_pkg;

  // Terminal behaviour select
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Count direction select
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Register width needed to hold 0..n-1, never less than one bit
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/counter_next_val.sv
// Combinational next-state function for one counter channel.
// Given the present count, terminal limit, direction and mode it returns the
// value the count takes on a counting edge and whether that edge is terminal.
// Kept free of registers so multi-channel counters can share it.
module counter_next_val
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] limit,
  input  logic             up,
  input  logic             mode,
  output logic [WIDTH-1:0] next_count,
  output logic             term
);

  // Up: terminal at or above the limit (a loaded value may exceed it).
  // Down: terminal only at zero; values above the limit just decrement.
  always_comb begin
    next_count = count;
    term       = 1'b0;
    if (up == DIR_UP) begin
      if (count >= limit) begin
        term       = 1'b1;
        next_count = (mode == MODE_WRAP) ? '0 : count;
      end else begin
        next_count = count + 1'b1;
      end
    end else begin
      if (count == '0) begin
        term       = 1'b1;
        next_count = (mode == MODE_WRAP) ? limit : '0;
      end else begin
        next_count = count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/updown_counter_ext.sv
// Parametrised up/down event/timer counter with programmable terminal value,
// wrap/saturate mode, registered terminal-count pulse, sticky overflow flag
// and a tri-state count output.
// Optional build macro: COUNTER_PRESCALE_EN adds a PRESCALE parameter and an
// internal prescaler so the count only steps every PRESCALE enabled edges.
module updown_counter_ext
  import counter_pkg::*;
#(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0,
  parameter logic [WIDTH-1:0] MAX_DEFAULT = {WIDTH{1'b1}}
`ifdef COUNTER_PRESCALE_EN
  ,
  parameter int unsigned      PRESCALE    = 4
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             set_limit,
  input  logic             enable,
  input  logic             up,
  input  logic             mode,
  input  logic             clr_flag,
  input  logic             oe,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] next_count;
  logic             term;
  logic             step;

  counter_next_val #(
    .WIDTH (WIDTH)
  ) u_next (
    .count      (count),
    .limit      (limit),
    .up         (up),
    .mode       (mode),
    .next_count (next_count),
    .term       (term)
  );

`ifdef COUNTER_PRESCALE_EN
  localparam int unsigned      PW       = cnt_width(PRESCALE);
  localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_cnt;

  assign step = enable && (pre_cnt == PRE_LAST);

  // Prescaler advances on every enabled edge and restarts on load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
    end else if (load) begin
      pre_cnt <= '0;
    end else if (enable) begin
      pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + 1'b1;
    end
  end
`else
  assign step = enable;
`endif

  // Limit register; written independently of load and counting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      limit <= MAX_DEFAULT;
    end else if (set_limit) begin
      limit <= load_value;
    end
  end

  // Count, terminal pulse and sticky flag; load outranks counting and never
  // raises tc/ovf, while a terminal step beats a simultaneous clr_flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= RESET_VAL;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else if (load) begin
      count <= load_value;
      tc    <= 1'b0;
      ovf   <= ovf & ~clr_flag;
    end else if (step) begin
      count <= next_count;
      tc    <= term;
      ovf   <= term | (ovf & ~clr_flag);
    end else begin
      tc    <= 1'b0;
      ovf   <= ovf & ~clr_flag;
    end
  end

  assign q = oe ? count : {WIDTH{1'bz}};

endmodule
